// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: absorbs rx strobes (no backpressure),
// presents a show-ahead valid/ready stream with delimiter marking and overflow accounting.
module uart_rx_fifo #(
  parameter int unsigned ASIZE     = 4,
  parameter logic [7:0]  LAST_BYTE = 8'h0A,
  parameter bit          USE_LAST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [7:0]       i_data,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [7:0]       o_tdata,
  output logic             o_tlast,
  output logic [ASIZE:0]   o_count,
  output logic             o_overflow,
  input  logic             i_clr_ovf,
  output logic [15:0]      o_drops
);

  localparam int unsigned   DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ASIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drops_q, drops_d;
  logic             rd, wr, drop;
  logic [7:0]       head;

  always_comb begin
    rd       = (count_q != '0) && o_tready;
    // A read at the same edge frees a slot, so a full FIFO still accepts.
    wr       = i_en && ((count_q != FULL_CNT) || rd);
    drop     = i_en && !wr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drops_d  = drops_q;
    if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (i_clr_ovf) begin
      ovf_d   = 1'b0;
      drops_d = '0;
    end
    // Clear and drop at the same edge: the drop is counted from zero.
    if (drop) begin
      ovf_d = 1'b1;
      if (drops_d != '1) drops_d = drops_d + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drops_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drops_q  <= drops_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) mem_q[wr_ptr_q] <= i_data;
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    o_tvalid   = (count_q != '0);
    o_tdata    = o_tvalid ? head : '0;
    o_tlast    = USE_LAST && o_tvalid && (head == LAST_BYTE);
    o_count    = count_q;
    o_overflow = ovf_q;
    o_drops    = drops_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus hand sequences for
// overflow, full-with-read, random ordering and mid-stream reset.
module tb_uart_rx_fifo;

  logic        clk;
  logic        rst, en, rdy, clr;
  logic [7:0]  data;
  logic        v0, l0, ovf0, v1, l1, ovf1;
  logic [7:0]  d0, d1;
  logic [4:0]  c0, c1;
  logic [15:0] dr0, dr1;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(.ASIZE(4), .LAST_BYTE(8'h0A), .USE_LAST(1'b1)) u0 (
    .clk(clk), .rst(rst), .i_en(en), .i_data(data),
    .o_tvalid(v0), .o_tready(rdy), .o_tdata(d0), .o_tlast(l0),
    .o_count(c0), .o_overflow(ovf0), .i_clr_ovf(clr), .o_drops(dr0));

  uart_rx_fifo #(.ASIZE(4), .LAST_BYTE(8'h0A), .USE_LAST(1'b0)) u1 (
    .clk(clk), .rst(rst), .i_en(en), .i_data(data),
    .o_tvalid(v1), .o_tready(rdy), .o_tdata(d1), .o_tlast(l1),
    .o_count(c1), .o_overflow(ovf1), .i_clr_ovf(clr), .o_drops(dr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rst, en;
    logic [7:0] data;
    logic       rdy, clr;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [4:0] cnt;
    logic       ovf;
    logic [15:0] drops;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] dd,
                      input logic rd_in, input logic cl);
    rst = r; en = e; data = dd; rdy = rd_in; clr = cl;
    @(posedge clk);
    #1;
    chk("nolast_tlast", {15'd0, l1}, 16'd0);
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_seq[16];
  int         mdrops;
  int         pushed;
  logic       m_rd, m_wr, r_en, r_rdy;
  logic [7:0] r_d;

  initial begin
    rst = 1'b1; en = 1'b0; data = '0; rdy = 1'b0; clr = 1'b0;

    //            rst en data  rdy clr  v  d      l cnt ovf drops
    vecs[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 5'd1, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'h4F, 1'b0, 1'b0, 1'b1, 8'h4F, 1'b0, 5'd1, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b1, 8'h4F, 1'b0, 5'd2, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 8'h4F, 1'b0, 5'd3, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h4F, 1'b0, 5'd4, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h4B, 1'b0, 5'd3, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 5'd2, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0A, 1'b1, 5'd1, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 5'd1, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 16'd0};

    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_valid", i), {15'd0, v0},  {15'd0, vecs[i].v});
      chk($sformatf("vec%0d_data", i),  {8'd0, d0},   {8'd0, vecs[i].d});
      chk($sformatf("vec%0d_last", i),  {15'd0, l0},  {15'd0, vecs[i].l});
      chk($sformatf("vec%0d_count", i), {11'd0, c0},  {11'd0, vecs[i].cnt});
      chk($sformatf("vec%0d_ovf", i),   {15'd0, ovf0}, {15'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_drops", i), dr0,          vecs[i].drops);
    end

    // Fill under backpressure, overflow, full+read, clear racing a drop.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", {11'd0, c0}, 16'(i + 1));
      chk("fill_head", {8'd0, d0}, 16'h0000);
      chk("fill_ovf", {15'd0, ovf0}, 16'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hF0 + 8'(i), 1'b0, 1'b0);
      chk("ovf_drops", dr0, 16'(i + 1));
      chk("ovf_flag", {15'd0, ovf0}, 16'd1);
      chk("ovf_count", {11'd0, c0}, 16'd16);
      chk("ovf_head", {8'd0, d0}, 16'h0000);
    end
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullrd_count", {11'd0, c0}, 16'd16);
    chk("fullrd_drops", dr0, 16'd3);
    chk("fullrd_head", {8'd0, d0}, 16'h0001);
    step(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1);
    chk("clrdrop_ovf", {15'd0, ovf0}, 16'd1);
    chk("clrdrop_drops", dr0, 16'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", {15'd0, ovf0}, 16'd0);
    chk("clr_drops", dr0, 16'd0);
    for (int i = 0; i < 15; i++) exp_seq[i] = 8'(i + 1);
    exp_seq[15] = 8'hAA;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", {15'd0, v0}, 16'd1);
      chk("drain_data", {8'd0, d0}, {8'd0, exp_seq[i]});
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_count", {11'd0, c0}, 16'd0);
    chk("drain_valid_end", {15'd0, v0}, 16'd0);

    // Random traffic against a queue model; exercises pointer wrap and drops.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    q.delete();
    mdrops = 0;
    pushed = 0;
    for (int cyc = 0; cyc < 400 && pushed < 40; cyc++) begin
      r_en  = 1'($urandom_range(0, 1));
      r_d   = 8'($urandom);
      r_rdy = 1'($urandom_range(0, 1));
      m_rd  = (q.size() > 0) && r_rdy;
      m_wr  = r_en && ((q.size() < 16) || m_rd);
      if (r_en) pushed++;
      if (r_en && !m_wr && mdrops < 65535) mdrops++;
      step(1'b0, r_en, r_d, r_rdy, 1'b0);
      if (m_rd) void'(q.pop_front());
      if (m_wr) q.push_back(r_d);
      chk("rand_valid", {15'd0, v0}, {15'd0, (q.size() > 0)});
      chk("rand_count", {11'd0, c0}, 16'(q.size()));
      chk("rand_data", {8'd0, d0}, (q.size() > 0) ? {8'd0, q[0]} : 16'd0);
      chk("rand_drops", dr0, 16'(mdrops));
    end
    chk("rand_budget", 16'(pushed), 16'd40);
    for (int cyc = 0; cyc < 64 && q.size() > 0; cyc++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      void'(q.pop_front());
      chk("rdrain_data", {8'd0, d0}, (q.size() > 0) ? {8'd0, q[0]} : 16'd0);
    end
    chk("rdrain_count", {11'd0, c0}, 16'd0);

    // Reset mid-stream with a write and a ready pending in the same cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    chk("pre_rst_count", {11'd0, c0}, 16'd5);
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    chk("mid_rst_count", {11'd0, c0}, 16'd0);
    chk("mid_rst_valid", {15'd0, v0}, 16'd0);
    chk("mid_rst_data", {8'd0, d0}, 16'd0);
    step(1'b0, 1'b1, 8'h41, 1'b1, 1'b0);
    chk("post_rst_valid", {15'd0, v0}, 16'd1);
    chk("post_rst_data", {8'd0, d0}, 16'h0041);
    chk("post_rst_count", {11'd0, c0}, 16'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_empty", {15'd0, v0}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer directly downstream of the UART receiver. It absorbs the receiver's single-cycle rx_data/rx_en strobes, which carry no backpressure, into a FIFO. It presents the buffered bytes on a valid/ready stream, with end-of-line marking on a delimiter byte. It also reports FIFO fill level and drops bytes on overflow, with a sticky flag and a drop counter.

Parameters:
ASIZE, 4, log2 of capacity; capacity DEPTH = 2**ASIZE bytes (ASIZE 1..10)
LAST_BYTE, 8'h0A, o_tlast is asserted alongside any output byte equal to this value
USE_LAST, 1, 1 = o_tlast is active; 0 = o_tlast is tied 0

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
i_en  input  1  byte strobe from the receiver (rx_en); one cycle per byte
i_data  input  8  byte from the receiver (rx_data); valid when i_en=1
o_tvalid  output  1  output byte valid
o_tready  input  1  consumer ready; a transfer happens on a clk edge where o_tvalid & o_tready
o_tdata  output  8  output byte
o_tlast  output  1  o_tdata == LAST_BYTE (when USE_LAST=1)
o_count  output  ASIZE+1  bytes currently held, 0..DEPTH
o_overflow  output  1  sticky: at least one byte was dropped
i_clr_ovf  input  1  clears o_overflow and o_drops
o_drops  output  16  count of dropped bytes, saturates at 16'hFFFF

Behaviour:
- Reset: rst is sampled on the clk edge. After reset: o_tvalid=0, o_tdata=0, o_tlast=0, o_count=0, o_overflow=0, o_drops=0. FIFO contents are discarded.
- A reset asserted mid-stream empties the FIFO in that cycle, with no handshake required. Writes and reads in the reset cycle are ignored.
- Ordering: bytes leave in arrival order. No duplication. No loss except overflow drops.
- Write: i_en=1 at an edge with o_count<DEPTH stores i_data.
- Read: o_tvalid & o_tready at an edge removes the head byte.
- Simultaneous write and read at the same edge:
  - If count<DEPTH, both happen and o_count is unchanged.
  - If count==DEPTH, the write is also accepted because the read frees a slot. o_count stays DEPTH and no drop is recorded.
- Overflow: i_en=1 with o_count==DEPTH and no read at that edge drops the byte. o_overflow becomes 1 and o_drops increments, saturating.
- i_clr_ovf=1 at an edge clears o_overflow and o_drops to 0. If a drop occurs at the same edge, the drop wins: o_overflow=1 and o_drops=1.
- Latency: with the FIFO empty, a byte written at edge k gives o_tvalid=1 with that byte on o_tdata immediately after edge k. This is 1-cycle latency. The output is show-ahead: o_tdata presents the head byte whenever o_tvalid=1.
- Stability: while o_tvalid=1 and o_tready=0, o_tdata and o_tlast hold steady and o_tvalid stays 1.
- o_tvalid is 1 exactly when o_count>0.
- Pointers: read and write pointers are ASIZE bits and wrap modulo DEPTH. o_count is an explicit counter, which removes the full/empty ambiguity. Pointer wrap must not disturb ordering.
- o_tvalid must not depend combinationally on o_tready. o_tready may be held constant high.
- o_tlast is a pure function of the head byte; it does not depend on prior traffic.
- Input timing: i_en may be asserted on back-to-back cycles. Normally the receiver produces at most one byte per CLK_DIV cycles, but the block must handle i_en=1 every cycle.

Test Plan:
- Latency and reset: after reset, write 8'h41 at edge 0 with o_tready=1. Required: o_tvalid=1 and o_tdata=8'h41 after edge 0. The transfer happens at edge 1, then o_count=0 and o_tvalid=0. All outputs are 0 during reset.
- Backpressure: ASIZE=4, o_tready=0, write 8'h00..8'h0F on consecutive cycles. Required: o_count=16, o_overflow=0, o_tdata=8'h00 held stable. Then o_tready=1: 16 transfers deliver 8'h00..8'h0F in order, after which o_count=0.
- Overflow: fill to 16, then write 3 more bytes with o_tready=0. Required: o_overflow=1 and o_drops=3, and bytes 8'h00..8'h0F still emerge intact. i_clr_ovf for 1 cycle gives o_overflow=0 and o_drops=0.
- Full plus simultaneous read: at count=16, write 8'hAA and read at the same edge. Required: o_count stays 16, no drop, and 8'hAA emerges last.
- Delimiter: stream "OK\r\n" (8'h4F,8'h4B,8'h0D,8'h0A) with USE_LAST=1. Required: o_tlast=1 only with 8'h0A. With USE_LAST=0, o_tlast is never 1.
- Wrap and mid-operation reset: push 40 random bytes with random o_tready and check order against a scoreboard. Then assert rst at count=5. Required: o_count=0 and o_tvalid=0 after the reset edge, and the next write behaves as in the latency test.
